// File: rtl/nios2_oci_trace_pkg.sv
// rtl/nios2_oci_trace_pkg.sv - shared state type and helpers for the OCI trace collector
package nios2_oci_trace_pkg;

   typedef enum logic [1:0] {IDLE, UNPACK, DRAIN, DONE} trace_state_t;

   // Upper bounds for the slot helper; a snapshot wider than MAX_BUF_W is not supported.
   localparam int MAX_BUF_W   = 512;
   localparam int MAX_ENTRY_W = 64;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   function automatic logic [MAX_ENTRY_W-1:0] slot_extract(input logic [MAX_BUF_W-1:0] packed_buf,
                                                          input int idx, input int entry_w);
      return MAX_ENTRY_W'(packed_buf >> (idx * entry_w));
   endfunction

endpackage

// File: rtl/oci_trace_fifo.sv
// rtl/oci_trace_fifo.sv - show-ahead FIFO with flush, level and drop indication
module oci_trace_fifo
   import nios2_oci_trace_pkg::*;
#(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 16
)(
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic [DATA_W-1:0]          i_data,
   input  logic                       i_pop,
   output logic [DATA_W-1:0]          o_data,
   output logic                       o_valid,
   output logic [clog2(DEPTH+1)-1:0]  o_level,
   output logic                       o_drop
);
   localparam int AW = clog2(DEPTH);
   localparam int LW = clog2(DEPTH+1);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr, r_rd;
   logic [LW-1:0]     r_level;
   logic              w_empty, w_full, w_do_pop, w_do_push;

   assign w_empty   = (r_level == '0);
   assign w_full    = (r_level == LW'(DEPTH));
   assign w_do_pop  = i_pop && !w_empty;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign w_do_push = i_push && (!w_full || w_do_pop);
   assign o_drop    = i_push && w_full && !w_do_pop && !i_flush;
   assign o_data    = r_mem[r_rd];
   assign o_valid   = !w_empty;
   assign o_level   = r_level;

   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) r_mem[r_wr] <= i_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
      end else if (i_flush) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + AW'(1);
         if (w_do_pop)  r_rd <= r_rd + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/nios2_oci_trace_collector.sv
// rtl/nios2_oci_trace_collector.sv - unpacks DCT snapshots into a FIFO and runs end-of-test drain
module nios2_oci_trace_collector
   import nios2_oci_trace_pkg::*;
#(
   parameter int ENTRY_W = 10,
   parameter int SLOTS   = 3,
   parameter int CNT_W   = 4,
   parameter int DEPTH   = 16,
   parameter int OVF_W   = 8
)(
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [SLOTS*ENTRY_W-1:0]   dct_buffer,
   input  logic [CNT_W-1:0]           dct_count,
   input  logic                       dct_load,
   output logic                       load_ready,
   input  logic                       test_ending,
   input  logic                       test_has_ended,
   output logic [ENTRY_W-1:0]         ent_data,
   output logic                       ent_valid,
   input  logic                       ent_ready,
   output logic [clog2(DEPTH+1)-1:0]  fifo_level,
   output logic [OVF_W-1:0]           overflow_cnt,
   output logic                       count_err,
   output logic                       drain_done
);
   localparam int                SLOT_W    = clog2(SLOTS+1);
   localparam int                BUF_W     = SLOTS*ENTRY_W;
   localparam logic [CNT_W-1:0]  SLOTS_CNT = CNT_W'(SLOTS);
   localparam logic [SLOT_W-1:0] SLOTS_N   = SLOT_W'(SLOTS);

   trace_state_t        r_state;
   logic [BUF_W-1:0]    r_shadow;
   logic [SLOT_W-1:0]   r_n, r_slot;
   logic                r_pending_end, r_push, r_count_err, r_drain_done;
   logic [ENTRY_W-1:0]  r_push_data;
   logic [OVF_W-1:0]    r_ovf;
   logic [ENTRY_W-1:0]  w_slot_data;
   logic                w_accept, w_last, w_drop;

   assign load_ready   = (r_state == IDLE) && !r_pending_end;
   assign w_accept     = load_ready && dct_load && (dct_count != '0);
   assign w_last       = (r_slot == r_n - SLOT_W'(1));
   assign w_slot_data  = ENTRY_W'(slot_extract(MAX_BUF_W'(r_shadow), int'(r_slot), ENTRY_W));
   assign overflow_cnt = r_ovf;
   assign count_err    = r_count_err;
   assign drain_done   = r_drain_done;

   // Pushes are registered, so an in-flight push must land before DRAIN may finish.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_shadow      <= '0;
         r_n           <= '0;
         r_slot        <= '0;
         r_pending_end <= 1'b0;
         r_push        <= 1'b0;
         r_push_data   <= '0;
         r_count_err   <= 1'b0;
         r_drain_done  <= 1'b0;
      end else if (test_has_ended) begin
         r_state       <= DONE;
         r_push        <= 1'b0;
         r_pending_end <= 1'b0;
         r_drain_done  <= 1'b1;
      end else begin
         r_push <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_shadow      <= dct_buffer;
                  r_n           <= (dct_count > SLOTS_CNT) ? SLOTS_N : SLOT_W'(dct_count);
                  r_slot        <= '0;
                  r_pending_end <= test_ending;
                  r_state       <= UNPACK;
                  if (dct_count > SLOTS_CNT) r_count_err <= 1'b1;
               end else if (test_ending) begin
                  r_state <= DRAIN;
               end
            end
            UNPACK: begin
               r_push      <= 1'b1;
               r_push_data <= w_slot_data;
               r_slot      <= r_slot + SLOT_W'(1);
               if (test_ending) r_pending_end <= 1'b1;
               if (w_last) begin
                  r_state       <= (r_pending_end || test_ending) ? DRAIN : IDLE;
                  r_pending_end <= 1'b0;
               end
            end
            DRAIN: begin
               if (fifo_level == '0 && !r_push) begin
                  r_state      <= DONE;
                  r_drain_done <= 1'b1;
               end
            end
            DONE:    r_state <= DONE;
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ovf <= '0;
      end else if (w_drop && r_ovf != {OVF_W{1'b1}}) begin
         r_ovf <= r_ovf + OVF_W'(1);
      end
   end

   oci_trace_fifo #(
      .DATA_W (ENTRY_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_flush (test_has_ended),
      .i_push  (r_push),
      .i_data  (r_push_data),
      .i_pop   (ent_ready),
      .o_data  (ent_data),
      .o_valid (ent_valid),
      .o_level (fifo_level),
      .o_drop  (w_drop)
   );

endmodule

// File: tb/tb_nios2_oci_trace_collector.sv
// tb/tb_nios2_oci_trace_collector.sv - scoreboard bench for the OCI trace collector
module tb_nios2_oci_trace_collector;
   localparam int ENTRY_W = 10;
   localparam int SLOTS   = 3;
   localparam int CNT_W   = 4;
   localparam int DEPTH   = 16;
   localparam int OVF_W   = 8;
   localparam int LVL_W   = 5;

   logic                      clk = 1'b0;
   logic                      reset_n;
   logic [SLOTS*ENTRY_W-1:0]  dct_buffer;
   logic [CNT_W-1:0]          dct_count;
   logic                      dct_load;
   logic                      load_ready;
   logic                      test_ending;
   logic                      test_has_ended;
   logic [ENTRY_W-1:0]        ent_data;
   logic                      ent_valid;
   logic                      ent_ready;
   logic [LVL_W-1:0]          fifo_level;
   logic [OVF_W-1:0]          overflow_cnt;
   logic                      count_err;
   logic                      drain_done;

   int checks = 0;
   int failures = 0;
   logic [ENTRY_W-1:0] sb[$];

   always #5 clk = ~clk;

   nios2_oci_trace_collector #(
      .ENTRY_W(ENTRY_W), .SLOTS(SLOTS), .CNT_W(CNT_W), .DEPTH(DEPTH), .OVF_W(OVF_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
      .dct_load(dct_load), .load_ready(load_ready), .test_ending(test_ending),
      .test_has_ended(test_has_ended), .ent_data(ent_data), .ent_valid(ent_valid),
      .ent_ready(ent_ready), .fifo_level(fifo_level), .overflow_cnt(overflow_cnt),
      .count_err(count_err), .drain_done(drain_done)
   );

   // Every handshake seen by the consumer is compared against the oldest expected entry.
   always @(negedge clk) begin
      if (reset_n && ent_valid && ent_ready) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_pop unexpected entry actual=%h required=none", ent_data);
         end else begin
            logic [ENTRY_W-1:0] exp;
            exp = sb.pop_front();
            if (ent_data !== exp) begin
               failures++;
               $display("FAIL sb_data actual=%h required=%h", ent_data, exp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [SLOTS*ENTRY_W-1:0] b, input logic [CNT_W-1:0] c, input logic te);
      int w;
      w = 0;
      while (!load_ready && w < 50) begin
         tick();
         w++;
      end
      checks++;
      if (load_ready !== 1'b1) begin
         failures++;
         $display("FAIL load_wait load_ready=%b required=1", load_ready);
      end
      dct_buffer  = b;
      dct_count   = c;
      dct_load    = 1'b1;
      test_ending = te;
      tick();
      dct_load    = 1'b0;
      test_ending = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int w;
      w = 0;
      while (!(sb.size() == 0 && fifo_level == 0 && load_ready) && w < 200) begin
         tick();
         w++;
      end
      repeat (3) tick();
      checks++;
      if (sb.size() != 0 || fifo_level !== 0) begin
         failures++;
         $display("FAIL %s_drain pending=%0d level=%0d required=0", name, sb.size(), fifo_level);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({ent_valid, fifo_level, overflow_cnt, count_err, drain_done, load_ready} !==
          {1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL reset valid=%b level=%0d ovf=%0d cerr=%b done=%b lr=%b required 0/0/0/0/0/1",
                  ent_valid, fifo_level, overflow_cnt, count_err, drain_done, load_ready);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      ent_ready = 1'b1;
      sb.push_back(10'h1); sb.push_back(10'h2); sb.push_back(10'h3);
      do_load({10'h3, 10'h2, 10'h1}, 4'd3, 1'b0);
      checks++;
      if (load_ready !== 1'b0 || ent_valid !== 1'b0) begin
         failures++;
         $display("FAIL basic_k0 lr=%b valid=%b required 0/0", load_ready, ent_valid);
      end
      tick();
      checks++;
      if (load_ready !== 1'b0 || ent_valid !== 1'b0) begin
         failures++;
         $display("FAIL basic_k1 lr=%b valid=%b required 0/0", load_ready, ent_valid);
      end
      tick();
      checks++;
      if (load_ready !== 1'b0 || ent_valid !== 1'b1 || ent_data !== 10'h1) begin
         failures++;
         $display("FAIL basic_k2 lr=%b valid=%b data=%h required 0/1/001", load_ready, ent_valid, ent_data);
      end
      tick();
      checks++;
      if (load_ready !== 1'b1) begin
         failures++;
         $display("FAIL basic_k3 lr=%b required=1", load_ready);
      end
      wait_empty("basic");
   endtask

   task automatic test_count_err();
      ent_ready = 1'b1;
      sb.push_back(10'h4); sb.push_back(10'h5); sb.push_back(10'h6);
      do_load({10'h6, 10'h5, 10'h4}, 4'd5, 1'b0);
      checks++;
      if (count_err !== 1'b1) begin
         failures++;
         $display("FAIL count_err_set actual=%b required=1", count_err);
      end
      wait_empty("count_err");
      checks++;
      if (count_err !== 1'b1) begin
         failures++;
         $display("FAIL count_err_sticky actual=%b required=1", count_err);
      end
   endtask

   task automatic test_overflow();
      logic [SLOTS*ENTRY_W-1:0] b;
      ent_ready = 1'b0;
      for (int j = 0; j < 6; j++) begin
         for (int i = 0; i < SLOTS; i++) begin
            b[i*ENTRY_W +: ENTRY_W] = ENTRY_W'(10'h100 + 3*j + i);
            if (3*j + i < DEPTH) sb.push_back(ENTRY_W'(10'h100 + 3*j + i));
         end
         do_load(b, 4'd3, 1'b0);
      end
      repeat (4) tick();
      checks++;
      if (fifo_level !== 5'd16 || overflow_cnt !== 8'd2) begin
         failures++;
         $display("FAIL ovf_full level=%0d ovf=%0d required 16/2", fifo_level, overflow_cnt);
      end
      repeat (3) tick();
      checks++;
      if (ent_valid !== 1'b1 || ent_data !== 10'h100) begin
         failures++;
         $display("FAIL ovf_head_stable valid=%b data=%h required 1/100", ent_valid, ent_data);
      end
      // Pops line up with the three pushes so the full FIFO never drops.
      sb.push_back(10'h200); sb.push_back(10'h201); sb.push_back(10'h202);
      do_load({10'h202, 10'h201, 10'h200}, 4'd3, 1'b0);
      tick();
      ent_ready = 1'b1;
      repeat (3) tick();
      ent_ready = 1'b0;
      checks++;
      if (fifo_level !== 5'd16 || overflow_cnt !== 8'd2) begin
         failures++;
         $display("FAIL full_pushpop level=%0d ovf=%0d required 16/2", fifo_level, overflow_cnt);
      end
      ent_ready = 1'b1;
      wait_empty("overflow");
      checks++;
      if (overflow_cnt !== 8'd2) begin
         failures++;
         $display("FAIL ovf_hold actual=%0d required=2", overflow_cnt);
      end
   endtask

   task automatic test_flush();
      ent_ready = 1'b0;
      do_load({10'h303, 10'h302, 10'h301}, 4'd3, 1'b0);
      do_load({10'h0, 10'h0, 10'h304}, 4'd1, 1'b0);
      do_load({10'h307, 10'h306, 10'h305}, 4'd3, 1'b0);
      tick();
      tick();
      checks++;
      if (fifo_level !== 5'd5 || load_ready !== 1'b0) begin
         failures++;
         $display("FAIL flush_pre level=%0d lr=%b required 5/0", fifo_level, load_ready);
      end
      test_has_ended = 1'b1;
      tick();
      test_has_ended = 1'b0;
      checks++;
      if ({fifo_level, ent_valid, drain_done, overflow_cnt, count_err, load_ready} !==
          {5'd0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL flush level=%0d valid=%b done=%b ovf=%0d cerr=%b lr=%b required 0/0/1/2/1/0",
                  fifo_level, ent_valid, drain_done, overflow_cnt, count_err, load_ready);
      end
      repeat (2) tick();
      checks++;
      if (fifo_level !== 5'd0 || ent_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_hold level=%0d valid=%b required 0/0", fifo_level, ent_valid);
      end
   endtask

   task automatic test_async_reset();
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({ent_valid, fifo_level, overflow_cnt, count_err, drain_done, load_ready} !==
          {1'b0, 5'd0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL async_reset valid=%b level=%0d ovf=%0d cerr=%b done=%b lr=%b required 0/0/0/0/0/1",
                  ent_valid, fifo_level, overflow_cnt, count_err, drain_done, load_ready);
      end
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_drain();
      int seen_nz, zero_at, done_at;
      seen_nz = 0;
      zero_at = -1;
      done_at = -1;
      ent_ready = 1'b1;
      sb.push_back(10'h21); sb.push_back(10'h22);
      do_load({10'h0, 10'h22, 10'h21}, 4'd2, 1'b1);
      for (int c = 0; c < 40; c++) begin
         if (drain_done) begin
            done_at = c;
            break;
         end
         if (fifo_level != 0) seen_nz = 1;
         else if (seen_nz != 0 && zero_at < 0) zero_at = c;
         tick();
      end
      checks++;
      if (done_at < 0 || zero_at < 0 || done_at != zero_at + 1 || sb.size() != 0) begin
         failures++;
         $display("FAIL drain_timing done_at=%0d zero_at=%0d pending=%0d required done_at=zero_at+1, pending 0",
                  done_at, zero_at, sb.size());
      end
      dct_buffer = {10'h33, 10'h32, 10'h31};
      dct_count  = 4'd3;
      dct_load   = 1'b1;
      repeat (5) tick();
      checks++;
      if (load_ready !== 1'b0) begin
         failures++;
         $display("FAIL done_lr actual=%b required=0", load_ready);
      end
      dct_load = 1'b0;
      repeat (3) tick();
      checks++;
      if (fifo_level !== 5'd0 || ent_valid !== 1'b0 || drain_done !== 1'b1) begin
         failures++;
         $display("FAIL done_ignore level=%0d valid=%b done=%b required 0/0/1", fifo_level, ent_valid, drain_done);
      end
   endtask

   initial begin
      reset_n        = 1'b0;
      dct_buffer     = '0;
      dct_count      = '0;
      dct_load       = 1'b0;
      test_ending    = 1'b0;
      test_has_ended = 1'b0;
      ent_ready      = 1'b0;
      test_reset();
      test_basic();
      test_count_err();
      test_overflow();
      test_flush();
      test_async_reset();
      test_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nios2_oci_trace_collector.md
Name: nios2_oci_trace_collector

Overview:
- Parametrised successor to the Nios II OCI test-bench stub. It consumes packed debug-control-trace (DCT) buffer snapshots and unpacks them into a show-ahead FIFO, one entry per cycle.
- It hands entries to a valid/ready consumer, counts overflow drops, and runs an end-of-test drain/flush sequence driven by test_ending and test_has_ended.
- It sits beside the OCI, in the simulation/debug capture path.

Parameters:
- ENTRY_W, 10: bits per DCT entry.
- SLOTS, 3: entries packed in dct_buffer, LSB-first; the buffer width is SLOTS*ENTRY_W.
- CNT_W, 4: width of dct_count.
- DEPTH, 16: FIFO depth in entries; must be a power of 2 and at least 2.
- OVF_W, 8: width of the overflow counter, which saturates.

Ports:
- clk, in, 1: single clock, rising edge.
- reset_n, in, 1: asynchronous active-low reset.
- dct_buffer, in, SLOTS*ENTRY_W: packed entries; slot i occupies bits [i*ENTRY_W +: ENTRY_W].
- dct_count, in, CNT_W: number of valid slots, counted from slot 0.
- dct_load, in, 1: snapshot strobe, sampled only when load_ready=1.
- load_ready, out, 1: collector accepts a snapshot this cycle.
- test_ending, in, 1: request a graceful drain.
- test_has_ended, in, 1: hard stop and flush.
- ent_data, out, ENTRY_W: FIFO head entry.
- ent_valid, out, 1: ent_data is valid.
- ent_ready, in, 1: consumer pops when ent_valid&ent_ready.
- fifo_level, out, clog2(DEPTH+1): current occupancy.
- overflow_cnt, out, OVF_W: number of entries dropped because the FIFO was full; saturates.
- count_err, out, 1: sticky; set when dct_count>SLOTS was accepted.
- drain_done, out, 1: sticky; end-of-test complete.

Behaviour:
- Reset:
  - state=IDLE; FIFO empty.
  - ent_valid=0, fifo_level=0, overflow_cnt=0, count_err=0, drain_done=0.
  - load_ready=1; it is a combinational decode of IDLE with no pending_end.
  - ent_data is don't-care while ent_valid=0.
  - Reset asserted mid-operation discards all state immediately.
- FSM states: IDLE, UNPACK, DRAIN, DONE.
- IDLE:
  - When dct_load=1 and dct_count!=0: latch the buffer into a shadow register, latch n=min(dct_count,SLOTS), and set slot=0. Go to UNPACK.
  - If dct_count>SLOTS on that accept, set count_err.
  - When dct_load=1 and dct_count==0: no effect; remain in IDLE.
  - test_ending=1 alone: go to DRAIN.
  - test_ending together with an accepted load: set pending_end; the load is processed first.
- UNPACK:
  - Each cycle, push shadow slot[slot] into the FIFO and increment slot.
  - After the push of slot n-1, go to DRAIN if pending_end or test_ending seen during UNPACK; otherwise go to IDLE.
  - load_ready=0 throughout UNPACK.
- FIFO push/pop rules:
  - Push when full with no pop in the same cycle: the entry is dropped, overflow_cnt increments (saturating at 2^OVF_W-1), and slot still advances.
  - Push and pop in the same cycle when full: the entry is accepted.
  - Push and pop in the same cycle when empty: the push is accepted and ent_valid rises next cycle; there is no fall-through.
- Latency: dct_load accepted at edge k puts entry 0 at the head with ent_valid=1 after edge k+2, provided the FIFO was empty. Throughput is 1 entry per cycle.
- FIFO: show-ahead. ent_data is stable while ent_valid=1 and ent_ready=0. Pointers wrap modulo DEPTH. Levels DEPTH (full) and 0 (empty) are both representable.
- DRAIN:
  - No loads are accepted; the consumer continues popping.
  - When fifo_level==0, go to DONE and set drain_done=1 on the same edge.
- DONE:
  - load_ready=0 and drain_done=1 until reset.
  - Pops continue normally; in practice the FIFO is empty.
- test_has_ended=1 in any state:
  - On the next edge: state=DONE, FIFO flushed (fifo_level=0, ent_valid=0), drain_done=1, pending_end cleared.
  - It overrides a simultaneous load, push or pop.
  - overflow_cnt and count_err are retained.
- test_ending is level-sensitive and is ignored in DRAIN and DONE.

Decomposition:
- Package nios2_oci_trace_pkg:
  - state enum {IDLE,UNPACK,DRAIN,DONE}.
  - clog2 function.
  - slot-extract helper function.
- Sub-module oci_trace_fifo:
  - Parameterised by DATA_W and DEPTH.
  - Synchronous show-ahead FIFO with push/pop, full/empty/level, and flush.
  - Asynchronous active-low reset.

Test Plan:
- Load dct_buffer={10'h3,10'h2,10'h1}, dct_count=3, ent_ready=1 -> ent_data 1,2,3 on consecutive cycles; first valid 2 cycles after accept; load_ready low for 3 cycles.
- Load dct_count=5 (SLOTS=3) -> exactly 3 entries emitted; count_err=1 and stays 1 until reset.
- ent_ready=0, 6 loads of 3 entries with DEPTH=16 -> fifo_level=16, overflow_cnt=2; then ent_ready=1 -> the 16 entries drain in order, with the 2 newest absent.
- Full FIFO with a simultaneous push and pop in UNPACK -> no drop; overflow_cnt unchanged; level stays 16.
- test_ending pulsed in the same cycle as a load of 2, ent_ready=1 -> 2 entries emitted, then drain_done=1 the cycle after fifo_level hits 0; later loads are ignored.
- test_has_ended mid-UNPACK with 5 entries queued -> next cycle fifo_level=0, ent_valid=0, drain_done=1, overflow_cnt preserved; reset_n low then clears all outputs asynchronously.
